// File: rtl/ahb_arb_pkg.sv
// Shared constants and types for the AHB master arbiter: HTRANS codes,
// arbiter state encoding and the per-cycle grant decision.
package ahb_arb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        ST_PARK = 2'd0,
        ST_OWN  = 2'd1,
        ST_LOCK = 2'd2
    } arb_state_e;

    // What the grant register does on the next accepted edge.
    typedef enum logic [1:0] {
        ACT_KEEP = 2'd0,
        ACT_WIN  = 2'd1,
        ACT_PARK = 2'd2
    } arb_act_e;

endpackage

// File: rtl/ahb_master_arbiter_if.sv
// Arbitration bus between the AHB masters / bridge ready and the arbiter.
// The master modport is the requester side, the slave modport is the arbiter.
interface ahb_master_arbiter_if #(
    parameter int unsigned NUM_MASTERS = 4
);
    logic [NUM_MASTERS-1:0]         hbusreq;
    logic [NUM_MASTERS-1:0]         hlock;
    logic [1:0]                     htrans;
    logic                           hready;
    logic [NUM_MASTERS-1:0]         hgrant;
    logic [$clog2(NUM_MASTERS)-1:0] hmaster;
    logic                           hmastlock;

    modport master (
        output hbusreq, hlock, htrans, hready,
        input  hgrant, hmaster, hmastlock
    );

    modport slave (
        input  hbusreq, hlock, htrans, hready,
        output hgrant, hmaster, hmastlock
    );
endinterface

// File: rtl/ahb_master_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after ptr, wrapping
// modulo NUM_MASTERS; returns the winner one-hot and as an index.
module ahb_master_arbiter_rr_pick #(
    parameter int unsigned NUM_MASTERS = 4
) (
    input  logic [NUM_MASTERS-1:0]         req,
    input  logic [$clog2(NUM_MASTERS)-1:0] ptr,
    output logic [NUM_MASTERS-1:0]         gnt,
    output logic [$clog2(NUM_MASTERS)-1:0] idx,
    output logic                           valid
);
    localparam int unsigned IW = $clog2(NUM_MASTERS);

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
            if (!valid && req[IW'((32'(ptr) + k) % NUM_MASTERS)]) begin
                valid = 1'b1;
                idx   = IW'((32'(ptr) + k) % NUM_MASTERS);
            end
        end
        if (valid) begin
            gnt[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/ahb_master_arbiter.sv
// Round-robin AHB bus arbiter with locked sequences, a max-hold limit and
// parking on DEFAULT_MASTER. Every register advances only when hready=1.
module ahb_master_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = 4,
    parameter int unsigned DEFAULT_MASTER = 0,
    parameter int unsigned MAX_HOLD       = 16
) (
    input  logic                hclk,
    input  logic                hreset,
    ahb_master_arbiter_if.slave bus
);
    localparam int unsigned IW = $clog2(NUM_MASTERS);
    localparam int unsigned CW = $clog2(MAX_HOLD + 1);
    localparam logic [IW-1:0]          DEF_IDX  = IW'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] DEF_OH   = NUM_MASTERS'(1) << DEFAULT_MASTER;
    localparam logic [CW-1:0]          HOLD_MAX = CW'(MAX_HOLD);

    arb_state_e             state_q, state_d;
    arb_act_e               act;
    logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
    logic [IW-1:0]          gnt_idx_q, gnt_idx_d;
    logic [IW-1:0]          ptr_q, ptr_d;
    logic [CW-1:0]          hold_q, hold_d;
    logic [IW-1:0]          hmaster_q, hmaster_d;
    logic                   hmastlock_q, hmastlock_d;

    logic                   own_req, own_lock, beat;
    logic [NUM_MASTERS-1:0] oth_gnt, win_gnt;
    logic [IW-1:0]          oth_idx, win_idx;
    logic                   oth_valid, win_valid;

    assign own_req  = bus.hbusreq[gnt_idx_q];
    assign own_lock = bus.hlock[gnt_idx_q];
    assign beat     = (bus.htrans != HTRANS_IDLE) && (bus.htrans != HTRANS_BUSY);

    // Other masters are searched first; the current owner only wins when alone.
    ahb_master_arbiter_rr_pick #(
        .NUM_MASTERS(NUM_MASTERS)
    ) u_rr_pick (
        .req  (bus.hbusreq & ~gnt_q),
        .ptr  (ptr_q),
        .gnt  (oth_gnt),
        .idx  (oth_idx),
        .valid(oth_valid)
    );

    assign win_valid = oth_valid || own_req;
    assign win_gnt   = oth_valid ? oth_gnt : gnt_q;
    assign win_idx   = oth_valid ? oth_idx : gnt_idx_q;

    // State and registered outputs
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q     <= ST_PARK;
            gnt_q       <= DEF_OH;
            gnt_idx_q   <= DEF_IDX;
            ptr_q       <= DEF_IDX;
            hold_q      <= '0;
            hmaster_q   <= DEF_IDX;
            hmastlock_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            ptr_q       <= ptr_d;
            hold_q      <= hold_d;
            hmaster_q   <= hmaster_d;
            hmastlock_q <= hmastlock_d;
        end
    end

    // Next state and grant decision; lock hold beats owner drop beats hold limit
    always_comb begin
        state_d = state_q;
        act     = ACT_KEEP;
        if (bus.hready) begin
            unique case (state_q)
                ST_PARK: begin
                    if (win_valid) begin
                        state_d = ST_OWN;
                        act     = ACT_WIN;
                    end
                end
                ST_OWN: begin
                    if (own_lock && (bus.htrans == HTRANS_NONSEQ)) begin
                        state_d = ST_LOCK;
                    end else if (!own_req) begin
                        if (win_valid) begin
                            act = ACT_WIN;
                        end else begin
                            state_d = ST_PARK;
                            act     = ACT_PARK;
                        end
                    end else if ((hold_q == HOLD_MAX) && oth_valid) begin
                        act = ACT_WIN;
                    end
                end
                ST_LOCK: begin
                    if (!own_lock && ((bus.htrans == HTRANS_IDLE) ||
                                      (bus.htrans == HTRANS_NONSEQ))) begin
                        if (win_valid) begin
                            state_d = ST_OWN;
                            act     = ACT_WIN;
                        end else begin
                            state_d = ST_PARK;
                            act     = ACT_PARK;
                        end
                    end
                end
                default: begin
                    state_d = ST_PARK;
                    act     = ACT_PARK;
                end
            endcase
        end
    end

    // Next values of grant, pointer, hold counter and address-phase owner
    always_comb begin
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        ptr_d       = ptr_q;
        hold_d      = hold_q;
        hmaster_d   = hmaster_q;
        hmastlock_d = hmastlock_q;
        if (bus.hready) begin
            hmaster_d   = gnt_idx_q;
            hmastlock_d = (state_q == ST_LOCK);
            unique case (act)
                ACT_WIN: begin
                    gnt_d     = win_gnt;
                    gnt_idx_d = win_idx;
                    ptr_d     = win_idx;
                end
                ACT_PARK: begin
                    gnt_d     = DEF_OH;
                    gnt_idx_d = DEF_IDX;
                end
                default: ;
            endcase
            if (gnt_d != gnt_q) begin
                hold_d = '0;
            end else if (beat && (hold_q != HOLD_MAX)) begin
                hold_d = hold_q + CW'(1);
            end
        end
    end

    assign bus.hgrant    = gnt_q;
    assign bus.hmaster   = hmaster_q;
    assign bus.hmastlock = hmastlock_q;

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Self-checking bench for ahb_master_arbiter: directed scenarios followed by
// randomized traffic compared every cycle against a behavioural model.
module tb_ahb_master_arbiter;
    import ahb_arb_pkg::*;

    localparam int N    = 4;
    localparam int DEF  = 0;
    localparam int MAXH = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ahb_master_arbiter_if #(.NUM_MASTERS(N)) bus ();

    ahb_master_arbiter #(
        .NUM_MASTERS   (N),
        .DEFAULT_MASTER(DEF),
        .MAX_HOLD      (MAXH)
    ) dut (
        .hclk  (clk),
        .hreset(rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: owner index, parked/locked flags, hold count, rr pointer
    int m_owner, m_ptr, m_hold, m_hmaster;
    bit m_parked, m_locked, m_hmastlock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = DEF; m_ptr = DEF; m_hold = 0; m_hmaster = DEF;
        m_parked = 1'b1; m_locked = 1'b0; m_hmastlock = 1'b0;
    endtask

    task automatic model_step();
        int  o, pick, c;
        bit  win, park, was_locked;
        logic [1:0] tr;
        if (rst) begin
            model_reset();
            return;
        end
        if (!bus.hready) return;
        o = m_owner; tr = bus.htrans; was_locked = m_locked;
        pick = -1; win = 1'b0; park = 1'b0;
        for (int k = 1; k <= N; k++) begin
            c = (m_ptr + k) % N;
            if (pick < 0 && c != o && bus.hbusreq[c]) pick = c;
        end
        if (pick < 0 && bus.hbusreq[o]) pick = o;
        if (m_parked) begin
            if (pick >= 0) win = 1'b1;
        end else if (m_locked) begin
            if (!bus.hlock[o] && (tr == 2'b00 || tr == 2'b10)) begin
                m_locked = 1'b0;
                if (pick >= 0) win = 1'b1; else park = 1'b1;
            end
        end else if (bus.hlock[o] && tr == 2'b10) begin
            m_locked = 1'b1;
        end else if (!bus.hbusreq[o]) begin
            if (pick >= 0) win = 1'b1; else park = 1'b1;
        end else if (m_hold == MAXH && pick >= 0 && pick != o) begin
            win = 1'b1;
        end
        if (win) begin
            m_owner = pick; m_ptr = pick; m_parked = 1'b0;
        end else if (park) begin
            m_owner = DEF; m_parked = 1'b1;
        end
        if (m_owner != o) m_hold = 0;
        else if (tr[1] && m_hold < MAXH) m_hold = m_hold + 1;
        m_hmaster = o;
        m_hmastlock = was_locked;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("model_hgrant", 32'(bus.hgrant), 32'(1) << m_owner);
        chk("model_hmaster", 32'(bus.hmaster), 32'(m_hmaster));
        chk("model_hmastlock", 32'(bus.hmastlock), 32'(m_hmastlock));
        chk("onehot_hgrant", 32'($onehot(bus.hgrant)), 32'd1);
    endtask

    task automatic drive(input logic [3:0] req, input logic [3:0] lck,
                         input logic [1:0] tr, input logic rdy);
        bus.hbusreq = req; bus.hlock = lck; bus.htrans = tr; bus.hready = rdy;
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        drive(4'b0000, 4'b0000, HTRANS_IDLE, 1'b1);

        // Reset and idle parking
        tick();
        chk("reset_hgrant", 32'(bus.hgrant), 32'h1);
        chk("reset_hmaster", 32'(bus.hmaster), 32'h0);
        chk("reset_hmastlock", 32'(bus.hmastlock), 32'h0);
        rst = 1'b0;
        repeat (10) tick();
        chk("park_hgrant", 32'(bus.hgrant), 32'h1);
        chk("park_hmaster", 32'(bus.hmaster), 32'h0);

        // First arbitration from PARK, then owner drop
        drive(4'b0110, 4'b0000, HTRANS_IDLE, 1'b1);
        tick();
        chk("t2_grant_m1", 32'(bus.hgrant), 32'b0010);
        tick();
        chk("t2_hmaster_m1", 32'(bus.hmaster), 32'd1);
        drive(4'b0100, 4'b0000, HTRANS_IDLE, 1'b1);
        tick();
        chk("t2_drop_grant_m2", 32'(bus.hgrant), 32'b0100);

        // Hold limit forces handover after MAX_HOLD beats
        drive(4'b1100, 4'b0000, HTRANS_NONSEQ, 1'b1);
        for (int i = 0; i < MAXH; i++) begin
            tick();
            bus.htrans = HTRANS_SEQ;
        end
        chk("t3_hold_grant_m2", 32'(bus.hgrant), 32'b0100);
        tick();
        chk("t3_force_grant_m3", 32'(bus.hgrant), 32'b1000);

        // Locked sequence ignores the hold limit, then releases to M0
        drive(4'b1111, 4'b1000, HTRANS_NONSEQ, 1'b1);
        tick();
        for (int i = 0; i < 40; i++) begin
            bus.htrans = (i % 2 == 0) ? HTRANS_NONSEQ : HTRANS_SEQ;
            tick();
        end
        chk("t4_lock_grant", 32'(bus.hgrant), 32'b1000);
        chk("t4_hmastlock", 32'(bus.hmastlock), 32'd1);
        drive(4'b1111, 4'b0000, HTRANS_IDLE, 1'b1);
        tick();
        chk("t4_release_grant_m0", 32'(bus.hgrant), 32'b0001);

        // Wait states freeze a pending grant change
        drive(4'b0010, 4'b0000, HTRANS_IDLE, 1'b0);
        repeat (3) begin
            tick();
            chk("t5_frozen_grant", 32'(bus.hgrant), 32'b0001);
            chk("t5_frozen_hmaster", 32'(bus.hmaster), 32'd3);
        end
        bus.hready = 1'b1;
        tick();
        chk("t5_release_grant_m1", 32'(bus.hgrant), 32'b0010);
        chk("t5_release_hmaster", 32'(bus.hmaster), 32'd0);

        // Reset during a locked burst
        drive(4'b0100, 4'b0100, HTRANS_NONSEQ, 1'b1);
        tick();
        tick();
        bus.htrans = HTRANS_SEQ;
        tick();
        chk("t6_locked_grant", 32'(bus.hgrant), 32'b0100);
        chk("t6_locked_hmastlock", 32'(bus.hmastlock), 32'd1);
        rst = 1'b1;
        tick();
        chk("t6_rst_hgrant", 32'(bus.hgrant), 32'b0001);
        chk("t6_rst_hmaster", 32'(bus.hmaster), 32'd0);
        chk("t6_rst_hmastlock", 32'(bus.hmastlock), 32'd0);
        rst = 1'b0;

        // Random traffic: light and heavy request phases
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            if (i < 2000) bus.hbusreq = 4'($urandom);
            else bus.hbusreq = ($urandom_range(0, 19) == 0) ? 4'($urandom) : 4'hF;
            bus.hlock  = 4'($urandom & $urandom & $urandom);
            bus.htrans = 2'($urandom);
            bus.hready = ($urandom_range(0, 4) != 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
